mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator for the word-addressed data memory: converts MEM-stage load/store requests into that memory's Address/WriteData/MemRead/MemWrite protocol.
- Adds sub-word loads (LB/LBU/LH/LHU) with extension, and SB/SH via read-modify-write.
- Adds alignment and range checks.
- Stalls the pipeline through a ready handshake while a request is in flight.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the attached memory; word index >= MEM_WORDS is out of range.
- ADDR_WIDTH, 32, byte address width; data width is fixed at 32.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  3  mem_op_t operation code.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified for SB/SH.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access; valid with rsp_valid.
- Address  out  32  word-aligned memory address, {addr[31:2],2'b00}.
- WriteData  out  32  memory write word.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe; memory commits on posedge clk.
- ReadData  in  32  combinational memory read data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, Address=0, WriteData=0, MemRead=0, MemWrite=0.
- Reset mid-operation: the request is abandoned with no response. A reset during RMW_RD or before RMW_WR leaves memory unchanged.
- Accept: in IDLE, on an edge with req_valid=1, latch op, addr and wdata. A request is never dropped while req_ready=1.
- Checks at accept:
  - Misaligned if a word op has addr[1:0]!=0, or a half op has addr[0]!=0.
  - Out of range if addr[31:2] >= MEM_WORDS.
  - Either condition gives IDLE->RESP with err=1; MemRead and MemWrite are never asserted for that request.
- State machine:
  - IDLE: goes to LOAD for LW/LH/LHU/LB/LBU, to STORE for SW, to RMW_RD for SH/SB, or to RESP on error.
  - LOAD: MemRead=1. Capture the extracted and extended ReadData at the edge. Go to RESP.
  - STORE: MemWrite=1, WriteData=wdata. Go to RESP.
  - RMW_RD: MemRead=1. Capture ReadData into the merge register. Go to RMW_WR.
  - RMW_WR: MemWrite=1. WriteData is the merge word with the target lane replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; rsp_err as computed. Go to IDLE. The next request can be accepted in the following IDLE cycle.
- Latency from the accept edge to the rsp_valid cycle:
  - error: 1 cycle.
  - load or SW: 2 cycles.
  - SH/SB: 3 cycles.
- Lanes are little-endian: addr[1:0]=0 selects bits [7:0], 3 selects [31:24]. A halfword at addr[1]=1 selects [31:16].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- MemRead and MemWrite are never high in the same cycle. Both are registered/state-decoded and glitch-free relative to the clock.
- Address and WriteData hold their values during the strobe cycle and are don't-care otherwise; they are driven 0 in IDLE.
- Illegal state encodings recover to IDLE.

Optional Feature:
- MEM_ACCESS_STATS_EN defined:
  - Adds outputs load_count, store_count and err_count, each 16 bits.
  - Each is a saturating counter (holds at 0xFFFF) incremented in the RESP cycle according to the request outcome.
  - Counters clear on reset.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_access_pkg:
  - mem_op_t encoding: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
  - state_t: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
  - Helper constant WORD_BYTES=4.
- Sub-module mem_lane_align: purely combinational extract/extend for loads and lane merge for stores. The FSM lives in mem_access_unit.

Test Plan:
- Memory word 5 = 0xDEADBEEF. LW addr 0x14 -> MemRead pulse at Address 0x14; rsp_valid 2 cycles after accept; rsp_data=0xDEADBEEF, rsp_err=0.
- Same memory: LB 0x17 -> rsp_data 0xFFFFFFDE; LBU 0x14 -> 0x000000EF; LH 0x16 -> 0xFFFFDEAD; LHU 0x14 -> 0x0000BEEF.
- SH 0x16 wdata 0x00001234 -> MemRead pulse then MemWrite pulse with WriteData 0x1234BEEF. Response 3 cycles after accept; memory word 5 = 0x1234BEEF.
- LW 0x15 and SH 0x13 -> rsp_err=1 one cycle after accept; MemRead and MemWrite stay 0; memory unchanged.
- SW 0x100 (word 64) -> rsp_err=1, no MemWrite.
- SB 0x14 wdata 0xAA with rst_n low during RMW_RD -> no MemWrite, no rsp_valid; word 5 still 0xDEADBEEF; req_ready=1 after reset.
- Back-to-back: req_valid held high with 3 queued requests -> each accepted only in IDLE; responses in order; no request lost or duplicated.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access unit.
package mem_access_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_t;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOAD   = 3'd1;
    localparam state_t STORE  = 3'd2;
    localparam state_t RMW_RD = 3'd3;
    localparam state_t RMW_WR = 3'd4;
    localparam state_t RESP   = 3'd5;

    function automatic logic is_load(input mem_op_t op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW:         return off != 2'b00;
            OP_LH, OP_LHU, OP_SH: return off[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane handling: load extract/extend and store lane merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  sh;
    logic [31:0] shifted;

    assign sh      = {byte_off, 3'b000};
    assign shifted = rdata >> sh;

    always_comb begin
        load_data = shifted;
        case (op)
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0000, shifted[15:0]};
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h000000, shifted[7:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        merge_data = wdata;
        case (op)
            OP_SH:   merge_data = (rdata & ~(32'h0000_FFFF << sh)) | ({16'h0000, wdata[15:0]} << sh);
            OP_SB:   merge_data = (rdata & ~(32'h0000_00FF << sh)) | ({24'h000000, wdata[7:0]} << sh);
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory, with sub-word RMW stores.
// Optional MEM_ACCESS_STATS_EN adds saturating load/store/error counters.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// LOAD   | MemRead strobe, extended load data captured
// STORE  | MemWrite strobe with full word
// RMW_RD | MemRead strobe, merged word captured into WriteData
// RMW_WR | MemWrite strobe with merged word
// RESP   | one-cycle rsp_valid
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [31:0]           Address,
    output logic [31:0]           WriteData,
    output logic                  MemRead,
    output logic                  MemWrite,
    input  logic [31:0]           ReadData
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]           load_count,
    output logic [15:0]           store_count,
    output logic [15:0]           err_count
`endif
);

    localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

    state_t                state, nxt;
    mem_op_t               op_q, op_in;
    logic [ADDR_WIDTH-1:0] addr_q, addr_src;
    logic [31:0]           wdata_q;
    logic                  acc, req_err, strobe_n;
    logic [31:0]           load_data, merge_data;

    assign op_in    = mem_op_t'(req_op);
    assign acc      = (state == IDLE) && req_valid;
    assign req_err  = misaligned(op_in, req_addr[1:0]) || (req_addr[ADDR_WIDTH-1:2] >= WORD_LIMIT);
    assign addr_src = (state == IDLE) ? req_addr : addr_q;
    assign strobe_n = (nxt == LOAD) || (nxt == STORE) || (nxt == RMW_RD) || (nxt == RMW_WR);

    mem_lane_align u_lane (
        .op         (op_q),
        .byte_off   (addr_q[1:0]),
        .rdata      (ReadData),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)             nxt = RESP;
                    else if (is_load(op_in)) nxt = LOAD;
                    else if (op_in == OP_SW) nxt = STORE;
                    else                     nxt = RMW_RD;
                end
            end
            LOAD:    nxt = RESP;
            STORE:   nxt = RESP;
            RMW_RD:  nxt = RMW_WR;
            RMW_WR:  nxt = RESP;
            default: nxt = IDLE;
        endcase
    end

    // All outputs are registered from the next state so the strobes are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
            Address   <= 32'h0;
            WriteData <= 32'h0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            op_q      <= OP_LW;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
        end else begin
            state     <= nxt;
            req_ready <= (nxt == IDLE);
            rsp_valid <= (nxt == RESP);
            rsp_err   <= acc && req_err;
            rsp_data  <= (state == LOAD) ? load_data : 32'h0;
            MemRead   <= (nxt == LOAD) || (nxt == RMW_RD);
            MemWrite  <= (nxt == STORE) || (nxt == RMW_WR);
            Address   <= strobe_n ? 32'({addr_src[ADDR_WIDTH-1:2], 2'b00}) : 32'h0;
            WriteData <= (nxt == STORE)  ? req_wdata  :
                         (nxt == RMW_WR) ? merge_data : 32'h0;
            if (acc) begin
                op_q    <= op_in;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_count  <= 16'h0;
            store_count <= 16'h0;
            err_count   <= 16'h0;
        end else if (state == RESP) begin
            if (rsp_err)           err_count   <= sat_inc16(err_count);
            else if (is_load(op_q)) load_count <= sat_inc16(load_count);
            else                   store_count <= sat_inc16(store_count);
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an attached memory and a byte-level reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] load_count, store_count, err_count;
`endif

    mem_access_unit #(.MEM_WORDS(64), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .load_count  (load_count),
        .store_count (store_count),
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    assign ReadData = (Address[31:8] == 24'h0) ? mem[Address[7:2]] : 32'h0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0;
    int          cyc = 0, cur_rd = 0, cur_wr = 0, resp_count = 0;
    bit          in_flight = 1'b0, chk_en = 1'b0;
    bit          pend_rmw = 1'b0;
    int          pend_word = 0;
    logic [31:0] pend_old = 32'h0;
    logic [31:0] last_data = 32'h0, last_rd_addr = 32'h0, last_wr_data = 32'h0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-by-byte view of memory, applied at accept time.
    task automatic predict(input int op, input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
        int size, word, off;
        logic [31:0] w, v;
        size = (op == 0 || op == 5) ? 4 : (op == 1 || op == 2 || op == 6) ? 2 : 1;
        e.err       = ((addr % size) != 0) || (addr[31:2] >= 30'd64);
        e.exp_addr  = addr & 32'hFFFF_FFFC;
        e.exp_wdata = 32'h0;
        e.data      = 32'h0;
        e.exp_rd    = 0;
        e.exp_wr    = 0;
        e.acc       = cyc;
        pend_rmw    = 1'b0;
        if (e.err) begin
            e.lat = 1;
        end else begin
            word = int'(addr[7:2]);
            off  = int'(addr[1:0]);
            w    = ref_mem[word];
            if (op <= 4) begin
                v = 32'h0;
                for (int i = 0; i < size; i++)
                    v = v | (((w >> (8 * (off + i))) & 32'hFF) << (8 * i));
                if ((op == 1 || op == 3) && v[8 * size - 1])
                    v = v | (32'hFFFF_FFFF << (8 * size));
                e.data = v; e.exp_rd = 1; e.lat = 2;
            end else if (op == 5) begin
                ref_mem[word] = wd;
                e.exp_wr = 1; e.lat = 2; e.exp_wdata = wd;
            end else begin
                pend_rmw = 1'b1; pend_word = word; pend_old = w;
                for (int i = 0; i < size; i++)
                    w = (w & ~(32'hFF << (8 * (off + i)))) | (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
                ref_mem[word] = w;
                e.exp_rd = 1; e.exp_wr = 1; e.lat = 3; e.exp_wdata = w;
            end
        end
    endtask

    // Memory, accept monitor and per-cycle compare in one process.
    initial begin
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = i * 32'h0101_0101;
            ref_mem[i] = i * 32'h0101_0101;
        end
        mem[5]     = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk or negedge clk);
            if (clk) begin
                cyc++;
                if (MemWrite && Address[31:8] == 24'h0) mem[Address[7:2]] <= WriteData;
                if (!rst_n) begin
                    if (pend_rmw && cur_wr == 0) ref_mem[pend_word] = pend_old;
                    pend_rmw = 1'b0;
                    q.delete();
                    in_flight = 1'b0;
                end else if (req_valid && req_ready) begin
                    predict(int'(req_op), req_addr, req_wdata, e);
                    q.push_back(e);
                    cur_rd = 0; cur_wr = 0;
                    in_flight = 1'b1;
                end
            end else if (chk_en) begin
                chk("both_strobes", {31'h0, MemRead && MemWrite}, 32'h0);
                chk("req_ready", {31'h0, req_ready}, {31'h0, !in_flight});
                if (MemRead) begin
                    cur_rd++; last_rd_addr = Address;
                    chk("rd_pending", q.size(), 1);
                    if (q.size() > 0) chk("rd_addr", Address, q[0].exp_addr);
                end
                if (MemWrite) begin
                    cur_wr++; last_wr_data = WriteData;
                    chk("wr_pending", q.size(), 1);
                    if (q.size() > 0) begin
                        chk("wr_addr", Address, q[0].exp_addr);
                        chk("wr_data", WriteData, q[0].exp_wdata);
                    end
                end
                if (rsp_valid) begin
                    chk("rsp_pending", q.size(), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                        chk("latency", cyc - e.acc, e.lat - 1);
                        chk("rd_count", cur_rd, e.exp_rd);
                        chk("wr_count", cur_wr, e.exp_wr);
                    end
                    resp_count++;
                    last_data = rsp_data; last_err = rsp_err;
                    in_flight = 1'b0; pend_rmw = 1'b0;
                end else if (in_flight && q.size() > 0 && cyc > q[0].acc + q[0].lat + 2) begin
                    chk("rsp_timeout", cyc - q[0].acc, q[0].lat - 1);
                    void'(q.pop_front());
                    in_flight = 1'b0;
                end
            end
        end
    end

    task automatic do_req(input int op, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("ready_wait", {31'h0, n < 50}, 32'h1);
        req_op = op[2:0]; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (in_flight && n < 50) begin @(posedge clk); #1; n++; end
        chk("resp_wait", {31'h0, n < 50}, 32'h1);
    endtask

    task automatic load_chk(input string name, input int op, input logic [31:0] addr, input logic [31:0] exp);
        do_req(op, addr, 32'h0);
        chk(name, last_data, exp);
        chk({name, "_err"}, {31'h0, last_err}, 32'h0);
    endtask

    task automatic err_chk(input string name, input int op, input logic [31:0] addr);
        do_req(op, addr, 32'h5555_5555);
        chk(name, {31'h0, last_err}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc, n, idx, mism;
        int          b_op [3];
        logic [31:0] b_addr [3], b_wd [3];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_address", Address, 32'h0);
        chk("rst_writedata", WriteData, 32'h0);
        chk("rst_memread", {31'h0, MemRead}, 32'h0);
        chk("rst_memwrite", {31'h0, MemWrite}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; chk_en = 1'b1;

        load_chk("lw_14", 0, 32'h14, 32'hDEAD_BEEF);
        chk("lw_14_addr", last_rd_addr, 32'h14);
        load_chk("lb_17", 3, 32'h17, 32'hFFFF_FFDE);
        load_chk("lbu_14", 4, 32'h14, 32'h0000_00EF);
        load_chk("lh_16", 1, 32'h16, 32'hFFFF_DEAD);
        load_chk("lhu_14", 2, 32'h14, 32'h0000_BEEF);
        load_chk("lw_fc_last_word", 0, 32'hFC, 32'h3F3F_3F3F);

        err_chk("lw_15_misaligned", 0, 32'h15);
        err_chk("sh_13_misaligned", 6, 32'h13);
        err_chk("sw_100_range", 5, 32'h100);
        chk("mem5_after_errors", mem[5], 32'hDEAD_BEEF);

        // SB abandoned by reset while in RMW_RD
        rc = resp_count;
        req_op = 3'd7; req_addr = 32'h14; req_wdata = 32'h0000_00AA; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmw_rd_strobe", {31'h0, MemRead}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_memwrite", {31'h0, MemWrite}, 32'h0);
        chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_mid_mem5", mem[5], 32'hDEAD_BEEF);
        chk("rst_mid_no_resp", resp_count, rc);

        do_req(6, 32'h16, 32'h0000_1234);
        chk("sh_16_wdata", last_wr_data, 32'h1234_BEEF);
        chk("sh_16_err", {31'h0, last_err}, 32'h0);
        @(posedge clk); #1;
        chk("sh_16_mem5", mem[5], 32'h1234_BEEF);

        // three requests with req_valid held high
        b_op[0] = 7; b_addr[0] = 32'h15; b_wd[0] = 32'h0000_0077;
        b_op[1] = 5; b_addr[1] = 32'h20; b_wd[1] = 32'hCAFE_F00D;
        b_op[2] = 0; b_addr[2] = 32'h14; b_wd[2] = 32'h0;
        rc = resp_count; idx = 0; n = 0;
        req_op = b_op[0][2:0]; req_addr = b_addr[0]; req_wdata = b_wd[0]; req_valid = 1'b1;
        while (idx < 3 && n < 100) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                idx++;
                if (idx < 3) begin
                    req_op = b_op[idx][2:0]; req_addr = b_addr[idx]; req_wdata = b_wd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            n++;
        end
        req_valid = 1'b0;
        n = 0;
        while (in_flight && n < 50) begin @(posedge clk); #1; n++; end
        chk("b2b_done", {31'h0, n < 50}, 32'h1);
        chk("b2b_resp_count", resp_count - rc, 3);
        chk("b2b_last_data", last_data, 32'h1234_77EF);
        chk("b2b_mem8", mem[8], 32'hCAFE_F00D);
        chk("b2b_mem5", mem[5], 32'h1234_77EF);

        mism = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_vs_model", mism, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
